sram_access_ctrl: RTL and testbench

//  Sequences a column of 6T SRAM bit cells with shared bitline pair, PMOS precharge and

---
 rtl/sram_ctrl_pkg.sv | 19 +
 rtl/sram_wl_decoder.sv | 24 ++
 rtl/sram_access_ctrl.sv | 162 ++++++++++++++++
 tb/tb_sram_access_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the SRAM column access controller.
//   state_e : access sequencer phases (idle, precharge, wordline access, done)
//   row_sel : one bit of a bounds-checked one-hot row decode
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPre,
    StAccess,
    StDone
  } state_e;

  // True when 'row' is the selected row and the address lies inside the array.
  function automatic logic row_sel(input int unsigned addr, input int unsigned row,
                                   input int unsigned nwords);
    return (addr == row) && (addr < nwords);
  endfunction

endpackage

// File: rtl/sram_wl_decoder.sv
// Wordline decoder: address to one-hot row select, gated by an enable.
// Out-of-range addresses decode to all zeros.
//   en_i   : decode enable; all wordlines low when 0
//   addr_i : row address
//   wl_o   : one-hot (or zero) wordline vector
module sram_wl_decoder
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned NWords = 8,
  parameter int unsigned AddrW  = 3
) (
  input  logic              en_i,
  input  logic [AddrW-1:0]  addr_i,
  output logic [NWords-1:0] wl_o
);

  always_comb begin
    wl_o = '0;
    for (int unsigned i = 0; i < NWords; i++) begin
      wl_o[i] = en_i & row_sel(32'(addr_i), i, NWords);
    end
  end

endmodule

// File: rtl/sram_access_ctrl.sv
// Access sequencer for a 6T SRAM column with shared bitline pair.
// Takes one read/write request at a time and steps PRE -> ACCESS -> DONE so that
// precharge, wordline and write-driver phases never overlap. Returns sensed data or a
// write acknowledge as a single-cycle response pulse.
//   clk_i, rst_ni                   : clock, async active-low reset
//   req_valid_i/req_ready_o         : request handshake (ready only in idle)
//   req_we_i, req_addr_i, req_wdata_i : request op, row, write data
//   rsp_valid_o, rsp_err_o, rsp_rdata_o : completion pulse, out-of-range flag, read data
//   precharge_b_o, wl_o, we_o, din_o  : array controls (all registered)
//   bl_out_i                        : sensed bitline value from the array
module sram_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned NWords = 8,
  parameter int unsigned AddrW  = 3,
  parameter int unsigned DataW  = 1,
  parameter int unsigned PreCyc = 1,
  parameter int unsigned WlCyc  = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [AddrW-1:0]  req_addr_i,
  input  logic [DataW-1:0]  req_wdata_i,
  output logic              rsp_valid_o,
  output logic              rsp_err_o,
  output logic [DataW-1:0]  rsp_rdata_o,
  output logic              precharge_b_o,
  output logic [NWords-1:0] wl_o,
  output logic              we_o,
  output logic [DataW-1:0]  din_o,
  input  logic [DataW-1:0]  bl_out_i
);

  localparam int unsigned MaxCyc = (PreCyc > WlCyc) ? PreCyc : WlCyc;
  localparam int unsigned CntW   = $clog2(MaxCyc) + 1;

  state_e state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              op_we_q, op_we_d;
  logic              op_err_q, op_err_d;
  logic [AddrW-1:0]  op_addr_q, op_addr_d;
  logic [DataW-1:0]  op_wdata_q, op_wdata_d;
  logic              capture;

  logic              prech_b_q, prech_b_d;
  logic [NWords-1:0] wl_q, wl_d;
  logic              we_q, we_d;
  logic [DataW-1:0]  din_q, din_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DataW-1:0]  rdata_q, rdata_d;
  logic              in_access;

  assign req_ready_o = (state_q == StIdle);

  // Phase sequencing; the counter is reloaded on entry to each timed phase and counts down.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_we_d    = op_we_q;
    op_err_d   = op_err_q;
    op_addr_d  = op_addr_q;
    op_wdata_d = op_wdata_q;
    capture    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          state_d    = StPre;
          cnt_d      = CntW'(PreCyc - 1);
          op_we_d    = req_we_i;
          op_addr_d  = req_addr_i;
          op_wdata_d = req_wdata_i;
          op_err_d   = (32'(req_addr_i) >= NWords);
        end
      end
      StPre: begin
        if (cnt_q == '0) begin
          state_d = StAccess;
          cnt_d   = CntW'(WlCyc - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StAccess: begin
        if (cnt_q == '0) begin
          state_d = StDone;
          capture = !op_we_q && !op_err_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Array controls are derived from the next state and registered, so each output
  // changes on the same edge as the phase it belongs to.
  assign in_access = (state_d == StAccess);

  sram_wl_decoder #(
    .NWords(NWords),
    .AddrW (AddrW)
  ) u_wl_decoder (
    .en_i  (in_access),
    .addr_i(op_addr_q),
    .wl_o  (wl_d)
  );

  always_comb begin
    prech_b_d   = in_access || (state_d == StDone);
    we_d        = in_access && op_we_q;
    din_d       = in_access ? op_wdata_q : '0;
    rsp_valid_d = (state_d == StDone);
    rsp_err_d   = (state_d == StDone) && op_err_q;
    rdata_d     = capture ? bl_out_i : rdata_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_we_q     <= 1'b0;
      op_err_q    <= 1'b0;
      op_addr_q   <= '0;
      op_wdata_q  <= '0;
      prech_b_q   <= 1'b0;
      wl_q        <= '0;
      we_q        <= 1'b0;
      din_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_we_q     <= op_we_d;
      op_err_q    <= op_err_d;
      op_addr_q   <= op_addr_d;
      op_wdata_q  <= op_wdata_d;
      prech_b_q   <= prech_b_d;
      wl_q        <= wl_d;
      we_q        <= we_d;
      din_q       <= din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign precharge_b_o = prech_b_q;
  assign wl_o          = wl_q;
  assign we_o          = we_q;
  assign din_o         = din_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_rdata_o   = rdata_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Scoreboard bench: two controller instances (8 rows, 1/1 phases; 6 rows, 2/3 phases).
// Drivers push expected responses from hand-computed vector tables; per-instance monitors
// check every cycle's array controls against the request phase and pop on rsp_valid.
module tb_sram_access_ctrl;

  typedef struct {
    logic       we;
    logic [2:0] addr;
    logic       wd;
    logic       bl;
    logic [7:0] wl;
    logic       err;
    logic       rd;
  } vec_t;

  typedef struct {
    int         issue;
    logic [7:0] wl;
    logic       we;
    logic       din;
    logic       err;
    logic       rd;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  exp_t qa[$];
  exp_t qb[$];

  // Instance A: 8 rows, PRE=1, WL=1
  logic       a_rst_n, a_req_valid, a_req_ready, a_req_we, a_req_wdata;
  logic [2:0] a_req_addr;
  logic       a_rsp_valid, a_rsp_err, a_rsp_rdata, a_prech, a_we, a_din, a_bl;
  logic [7:0] a_wl;

  // Instance B: 6 rows, PRE=2, WL=3
  logic       b_rst_n, b_req_valid, b_req_ready, b_req_we, b_req_wdata;
  logic [2:0] b_req_addr;
  logic       b_rsp_valid, b_rsp_err, b_rsp_rdata, b_prech, b_we, b_din, b_bl;
  logic [5:0] b_wl;

  sram_access_ctrl #(
    .NWords(8), .AddrW(3), .DataW(1), .PreCyc(1), .WlCyc(1)
  ) u_dut_a (
    .clk_i        (clk),
    .rst_ni       (a_rst_n),
    .req_valid_i  (a_req_valid),
    .req_ready_o  (a_req_ready),
    .req_we_i     (a_req_we),
    .req_addr_i   (a_req_addr),
    .req_wdata_i  (a_req_wdata),
    .rsp_valid_o  (a_rsp_valid),
    .rsp_err_o    (a_rsp_err),
    .rsp_rdata_o  (a_rsp_rdata),
    .precharge_b_o(a_prech),
    .wl_o         (a_wl),
    .we_o         (a_we),
    .din_o        (a_din),
    .bl_out_i     (a_bl)
  );

  sram_access_ctrl #(
    .NWords(6), .AddrW(3), .DataW(1), .PreCyc(2), .WlCyc(3)
  ) u_dut_b (
    .clk_i        (clk),
    .rst_ni       (b_rst_n),
    .req_valid_i  (b_req_valid),
    .req_ready_o  (b_req_ready),
    .req_we_i     (b_req_we),
    .req_addr_i   (b_req_addr),
    .req_wdata_i  (b_req_wdata),
    .rsp_valid_o  (b_rsp_valid),
    .rsp_err_o    (b_rsp_err),
    .rsp_rdata_o  (b_rsp_rdata),
    .precharge_b_o(b_prech),
    .wl_o         (b_wl),
    .we_o         (b_we),
    .din_o        (b_din),
    .bl_out_i     (b_bl)
  );

  // {we, addr, wdata, bl_out, expected wl, expected err, expected rdata}
  vec_t va[8] = '{
    '{1'b1, 3'd5, 1'b1, 1'b0, 8'b0010_0000, 1'b0, 1'b0},
    '{1'b0, 3'd2, 1'b0, 1'b0, 8'b0000_0100, 1'b0, 1'b0},
    '{1'b0, 3'd5, 1'b0, 1'b1, 8'b0010_0000, 1'b0, 1'b1},
    '{1'b1, 3'd3, 1'b0, 1'b0, 8'b0000_1000, 1'b0, 1'b1},
    '{1'b0, 3'd1, 1'b0, 1'b0, 8'b0000_0010, 1'b0, 1'b0},
    '{1'b0, 3'd6, 1'b0, 1'b1, 8'b0100_0000, 1'b0, 1'b1},
    '{1'b1, 3'd7, 1'b0, 1'b0, 8'b1000_0000, 1'b0, 1'b1},
    '{1'b0, 3'd0, 1'b0, 1'b1, 8'b0000_0001, 1'b0, 1'b1}
  };
  vec_t va_rst = '{1'b0, 3'd4, 1'b0, 1'b1, 8'b0001_0000, 1'b0, 1'b1};

  vec_t vb[5] = '{
    '{1'b0, 3'd7, 1'b0, 1'b1, 8'b0000_0000, 1'b1, 1'b0},
    '{1'b0, 3'd4, 1'b0, 1'b1, 8'b0001_0000, 1'b0, 1'b1},
    '{1'b1, 3'd0, 1'b1, 1'b0, 8'b0000_0001, 1'b0, 1'b1},
    '{1'b0, 3'd6, 1'b0, 1'b0, 8'b0000_0000, 1'b1, 1'b1},
    '{1'b0, 3'd5, 1'b0, 1'b0, 8'b0010_0000, 1'b0, 1'b0}
  };

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // One monitor step; d is the cycle offset from the handshake sample of the oldest request.
  task automatic monitor(input string tag, input int pre, input int wlc, input bit have,
                         input exp_t e, input logic prech, input logic [7:0] wl, input logic we,
                         input logic din, input logic rv, input logic re, input logic rd,
                         output bit pop);
    int d;
    pop = 1'b0;
    d = have ? (cyc - e.issue) : 0;
    check({tag, " precharge/wl overlap"}, 32'(!prech && (wl != 8'h00)), 32'd0);
    check({tag, " wl onehot0"}, 32'($onehot0(wl)), 32'd1);
    if (rv) begin
      if (!have) begin
        check({tag, " unexpected rsp_valid"}, 32'(rv), 32'd0);
      end else begin
        check({tag, " rsp latency"}, 32'(d), 32'(pre + wlc + 1));
        check({tag, " done {prech,wl,we}"}, 32'({prech, wl, we}), 32'({1'b1, 8'h00, 1'b0}));
        check({tag, " rsp_err"}, 32'(re), 32'(e.err));
        check({tag, " rsp_rdata"}, 32'(rd), 32'(e.rd));
        pop = 1'b1;
      end
    end else if (d <= pre) begin
      check({tag, " idle/pre {prech,wl,we}"}, 32'({prech, wl, we}), 32'd0);
    end else if (d <= pre + wlc) begin
      check({tag, " access {prech,wl,we,din}"}, 32'({prech, wl, we, din}),
            32'({1'b1, e.wl, e.we, e.din}));
    end else begin
      check({tag, " rsp timeout"}, 32'(rv), 32'd1);
      pop = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    bit   pop;
    exp_t e;
    if (a_rst_n === 1'b1) begin
      e = '{default: '0};
      if (qa.size() > 0) e = qa[0];
      monitor("A", 1, 1, qa.size() > 0, e, a_prech, a_wl, a_we, a_din, a_rsp_valid,
              a_rsp_err, a_rsp_rdata, pop);
      if (pop) void'(qa.pop_front());
    end
  end

  always @(negedge clk) begin
    bit   pop;
    exp_t e;
    if (b_rst_n === 1'b1) begin
      e = '{default: '0};
      if (qb.size() > 0) e = qb[0];
      monitor("B", 2, 3, qb.size() > 0, e, b_prech, {2'b00, b_wl}, b_we, b_din, b_rsp_valid,
              b_rsp_err, b_rsp_rdata, pop);
      if (pop) void'(qb.pop_front());
    end
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic issue(input bit is_b, input vec_t v, input bit hold, output int at);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    at = -1;
    if (is_b) begin
      b_req_valid = 1'b1; b_req_we = v.we; b_req_addr = v.addr; b_req_wdata = v.wd;
    end else begin
      a_req_valid = 1'b1; a_req_we = v.we; a_req_addr = v.addr; a_req_wdata = v.wd;
    end
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if ((is_b ? b_req_ready : a_req_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check(is_b ? "B accept timeout" : "A accept timeout", 32'd0, 32'd1);
      if (is_b) b_req_valid = 1'b0;
      else a_req_valid = 1'b0;
      return;
    end
    // Previous access has completed by now, so bl_out can change safely.
    if (is_b) b_bl = v.bl;
    else a_bl = v.bl;
    e.issue = cyc;
    e.wl    = v.wl;
    e.we    = v.we;
    e.din   = v.wd;
    e.err   = v.err;
    e.rd    = v.rd;
    if (is_b) qb.push_back(e);
    else qa.push_back(e);
    at = cyc;
    @(posedge clk);
    #1;
    if (!hold) begin
      if (is_b) b_req_valid = 1'b0;
      else a_req_valid = 1'b0;
    end
  endtask

  initial begin
    a_rst_n = 1'b0; a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = 1'b0;
    a_bl = 1'b0;
    b_rst_n = 1'b0; b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = 1'b0;
    b_bl = 1'b0;
    repeat (2) @(negedge clk);
    check("A reset outputs", 32'({a_prech, a_wl, a_we, a_din, a_rsp_valid, a_rsp_err,
                                  a_rsp_rdata}), 32'd0);
    check("A reset req_ready", 32'(a_req_ready), 32'd1);
    check("B reset outputs", 32'({b_prech, b_wl, b_we, b_din, b_rsp_valid, b_rsp_err,
                                  b_rsp_rdata}), 32'd0);
    check("B reset req_ready", 32'(b_req_ready), 32'd1);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    @(posedge clk);
    #1;

    fork
      begin : seq_a
        int t, i0, i1, i2;
        for (int k = 0; k < 4; k++) issue(1'b0, va[k], 1'b0, t);
        issue(1'b0, va[4], 1'b1, i0);
        issue(1'b0, va[5], 1'b1, i1);
        issue(1'b0, va[6], 1'b0, i2);
        check("A back-to-back spacing 1", 32'(i1 - i0), 32'd4);
        check("A back-to-back spacing 2", 32'(i2 - i1), 32'd4);
        // Reset in the middle of the wordline phase.
        issue(1'b0, va_rst, 1'b0, t);
        @(negedge clk);
        @(negedge clk);
        #2;
        a_rst_n = 1'b0;
        #1;
        check("A reset mid-access {prech,wl,we}", 32'({a_prech, a_wl, a_we}), 32'd0);
        check("A reset mid-access rsp/rdata", 32'({a_rsp_valid, a_rsp_rdata}), 32'd0);
        qa.delete();
        @(negedge clk);
        @(negedge clk);
        a_rst_n = 1'b1;
        @(negedge clk);
        check("A req_ready after reset", 32'(a_req_ready), 32'd1);
        @(posedge clk);
        #1;
        issue(1'b0, va[7], 1'b0, t);
      end
      begin : seq_b
        int t;
        for (int k = 0; k < 5; k++) issue(1'b1, vb[k], 1'b0, t);
      end
    join

    for (int t = 0; t < 30 && (qa.size() > 0 || qb.size() > 0); t++) @(negedge clk);
    check("A responses outstanding", 32'(qa.size()), 32'd0);
    check("B responses outstanding", 32'(qb.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
